// File: rtl/adder_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
// Provides the controller state enum, the slice width and an index-width helper.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter over nib steps, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/cla_4bit_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Ports: a, b (addends), cin (carry in), s (sum), cout (carry out of bit 3).
module cla_4bit_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from generate/propagate terms.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced through one 4-bit CLA slice, LSB nibble first.
// Ports: clk, rst_n (sync, active-low); operand side in_valid/in_ready, a, b, cin, sub;
// result side out_valid/out_ready, sum, cout, ovf; busy while RUN or DONE.
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = idx_width(NIB);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;

  cla_4bit_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Operand nibble select for the current step.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < int'(NIB); i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        slice_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          work_d  = '0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < int'(NIB); i++) begin
          if (idx_q == IDX_W'(i)) begin
            work_d[i*NIBBLE_W +: NIBBLE_W] = slice_s;
          end
        end
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIB - 1)) begin
          // Operand MSBs hold the effective signs captured at accept.
          sum_d   = work_d;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: release result afterwards; 1: out_ready held high; 2: leave result pending.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                        input logic tsub, input int mode, input string nm,
                        output logic [15:0] rs, output logic rc, output logic ro);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd4);
    rs = sum; rc = cout; ro = ovf;
    if (mode == 0) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  vec_t vecs[9];

  initial begin
    logic [15:0] rs;
    logic        rc;
    logic        ro;
    int          lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, $sformatf("vec%0d", i), rs, rc, ro);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].exp_ovf));
    end
    check("idle_holds_sum", 32'(sum), 32'h0000);
    check("idle_holds_cout", 32'(cout), 32'd1);

    // Back-pressure with a competing operand request.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 2, "bp", rs, rc, ro);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'h5555);
      check("bp_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rel_out_valid", 32'(out_valid), 32'd0);
    check("bp_rel_in_ready", 32'(in_ready), 32'd1);
    check("bp_rel_sum_kept", 32'(sum), 32'h5555);
    tick();
    in_valid = 1'b0;
    check("bp_new_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_new_latency", 32'(lat), 32'd4);
    check("bp_new_sum", 32'(sum), 32'h3333);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset two RUN edges into an operation.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_rel_in_ready", 32'(in_ready), 32'd1);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, "post_rst", rs, rc, ro);
    check("post_rst_sum", 32'(rs), 32'h0100);
    check("post_rst_cout_ovf", {30'd0, rc, ro}, 32'd0);

    // Back-to-back random operations against an arithmetic model.
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra, rb, bb;
      logic        rcin, rsub;
      logic [16:0] full;
      logic        eovf;
      ra = 16'($urandom); rb = 16'($urandom);
      rcin = 1'($urandom); rsub = 1'($urandom);
      bb = rsub ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {16'd0, (rsub ? 1'b1 : rcin)};
      eovf = (ra[15] == bb[15]) && (full[15] != ra[15]);
      run_op(ra, rb, rcin, rsub, 1, $sformatf("rnd%0d", i), rs, rc, ro);
      check($sformatf("rnd%0d_sum", i), 32'(rs), 32'(full[15:0]));
      check($sformatf("rnd%0d_cout", i), 32'(rc), 32'(full[16]));
      check($sformatf("rnd%0d_ovf", i), 32'(ro), 32'(eovf));
    end
    tick();
    out_ready = 1'b0;
    check("final_idle", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
